// File: rtl/fifo_row_reader_pkg.sv
// Shared definitions for the FIFO row reader and its ring-buffer neighbours.
// Holds the controller state encoding and the default word width that the
// ring buffer and the row reader agree on.
package fifo_row_reader_pkg;

  localparam int WORDLEN_DEF = 8;

  // Encoding is fixed so that waveform viewers and neighbouring blocks agree.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/fifo_row_reader_row_assembler.sv
// row_assembler: ROWLEN x WORDLEN lane register with an indexed single-lane
// write and a synchronous clear.
// Ports:
//   clk      clock, rising edge
//   clr      synchronous clear of every lane
//   wr_en    write wr_data into lane wr_idx
//   wr_idx   lane index
//   wr_data  lane data
//   row_data packed lanes, lane k at [k*WORDLEN +: WORDLEN]
module row_assembler
  import fifo_row_reader_pkg::*;
#(
  parameter int WORDLEN = WORDLEN_DEF,
  parameter int ROWLEN  = 4,
  localparam int IDX_W  = $clog2(ROWLEN)
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic                      wr_en,
  input  logic [IDX_W-1:0]          wr_idx,
  input  logic [WORDLEN-1:0]        wr_data,
  output logic [ROWLEN*WORDLEN-1:0] row_data
);

  logic [ROWLEN-1:0][WORDLEN-1:0] lanes;

  always_ff @(posedge clk) begin
    if (clr) begin
      lanes <= '0;
    end else if (wr_en) begin
      lanes[wr_idx] <= wr_data;
    end
  end

  assign row_data = lanes;

endmodule

// File: rtl/fifo_row_reader.sv
// fifo_row_reader: pops words from the input staging FIFO, packs ROWLEN words
// into one row and offers it to the array edge loader on a valid/ready
// handshake. TILE_ROWS rows are produced per start command, followed by a
// one-cycle tile_done pulse.
// Ports:
//   clk, rstn   clock and synchronous active-low reset
//   start       single-cycle tile start, honoured only in IDLE
//   fifo_empty  FIFO empty flag
//   fifo_rd     FIFO pop strobe (data appears on fifo_dout one cycle later)
//   fifo_dout   FIFO registered read data
//   row_data    packed row, word k at [k*WORDLEN +: WORDLEN]
//   row_valid   row_data valid
//   row_ready   consumer accepts the row
//   busy        high outside IDLE
//   tile_done   one-cycle pulse after the last row of a tile is accepted
module fifo_row_reader
  import fifo_row_reader_pkg::*;
#(
  parameter int WORDLEN   = WORDLEN_DEF,
  parameter int ROWLEN    = 4,
  parameter int TILE_ROWS = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start,
  input  logic                      fifo_empty,
  output logic                      fifo_rd,
  input  logic [WORDLEN-1:0]        fifo_dout,
  output logic [ROWLEN*WORDLEN-1:0] row_data,
  output logic                      row_valid,
  input  logic                      row_ready,
  output logic                      busy,
  output logic                      tile_done
);

  localparam int CNT_W = $clog2(ROWLEN + 1);
  localparam int IDX_W = $clog2(ROWLEN);
  localparam int RC_W  = $clog2(TILE_ROWS) + 1;

  localparam logic [CNT_W-1:0] ROW_FULL = CNT_W'(ROWLEN);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(ROWLEN - 1);
  localparam logic [RC_W-1:0]  TILE_LAST = RC_W'(TILE_ROWS - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] issued;
  logic [CNT_W-1:0] captured;
  logic [RC_W-1:0]  row_cnt;
  logic             rd_pend;
  logic             cap_en;
  logic             last_row;

  // A pop issued this cycle returns data next cycle; rd_pend marks that slot.
  assign cap_en   = rd_pend && (state == FILL);
  assign last_row = (row_cnt == TILE_LAST);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      issued   <= '0;
      captured <= '0;
      row_cnt  <= '0;
      rd_pend  <= 1'b0;
    end else begin
      rd_pend <= fifo_rd;
      unique case (state)
        IDLE: begin
          if (start) begin
            issued   <= '0;
            captured <= '0;
            row_cnt  <= '0;
          end
        end
        FILL: begin
          if (fifo_rd) issued <= issued + 1'b1;
          if (cap_en) captured <= captured + 1'b1;
        end
        PRESENT: begin
          if (row_ready && !last_row) begin
            row_cnt  <= row_cnt + 1'b1;
            issued   <= '0;
            captured <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    fifo_rd   = 1'b0;
    row_valid = 1'b0;
    busy      = 1'b1;
    tile_done = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = FILL;
      end
      FILL: begin
        fifo_rd = !fifo_empty && (issued < ROW_FULL);
        // The capture that fills the final lane moves us to PRESENT.
        if (cap_en && (captured == ROW_LAST)) state_nxt = PRESENT;
      end
      PRESENT: begin
        row_valid = 1'b1;
        if (row_ready) state_nxt = last_row ? DONE : FILL;
      end
      DONE: begin
        tile_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  row_assembler #(
    .WORDLEN (WORDLEN),
    .ROWLEN  (ROWLEN)
  ) u_row_assembler (
    .clk      (clk),
    .clr      (!rstn),
    .wr_en    (cap_en),
    .wr_idx   (captured[IDX_W-1:0]),
    .wr_data  (fifo_dout),
    .row_data (row_data)
  );

endmodule

// File: tb/tb_fifo_row_reader.sv
// Directed bench for fifo_row_reader: a default instance (ROWLEN=4,
// TILE_ROWS=4) fed from a small FIFO model, plus a ROWLEN=2, TILE_ROWS=1
// instance fed from an always-ready word source.
module tb_fifo_row_reader;

  logic        clk;
  logic        rstn;
  logic        start;
  logic        fifo_empty;
  logic        fifo_rd;
  logic [7:0]  fifo_dout;
  logic [31:0] row_data;
  logic        row_valid;
  logic        row_ready;
  logic        busy;
  logic        tile_done;

  logic        start2;
  logic        fifo_empty2;
  logic        fifo_rd2;
  logic [7:0]  fifo_dout2;
  logic [15:0] row_data2;
  logic        row_valid2;
  logic        row_ready2;
  logic        busy2;
  logic        tile_done2;

  int tests = 0;
  int fails = 0;

  logic [7:0] mem [0:127];
  int         wp = 0;
  int         rp = 0;
  logic [7:0] d2 = 8'hA1;

  fifo_row_reader #(.WORDLEN(8), .ROWLEN(4), .TILE_ROWS(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .fifo_dout  (fifo_dout),
    .row_data   (row_data),
    .row_valid  (row_valid),
    .row_ready  (row_ready),
    .busy       (busy),
    .tile_done  (tile_done)
  );

  fifo_row_reader #(.WORDLEN(8), .ROWLEN(2), .TILE_ROWS(1)) dut_small (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start2),
    .fifo_empty (fifo_empty2),
    .fifo_rd    (fifo_rd2),
    .fifo_dout  (fifo_dout2),
    .row_data   (row_data2),
    .row_valid  (row_valid2),
    .row_ready  (row_ready2),
    .busy       (busy2),
    .tile_done  (tile_done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model with registered read data
  initial fifo_dout = 8'h00;
  assign fifo_empty = (rp == wp);
  always @(posedge clk) begin
    if (fifo_rd && (rp != wp)) begin
      fifo_dout <= mem[rp % 128];
      rp <= rp + 1;
    end
  end

  // Word source for the small instance: never empty, counts up from 0xA1
  initial fifo_dout2 = 8'h00;
  always @(posedge clk) begin
    if (fifo_rd2) begin
      fifo_dout2 <= d2;
      d2 <= d2 + 8'd1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      mem[wp % 128] = first + 8'(i);
      wp = wp + 1;
    end
  endtask

  function automatic logic [31:0] row_of(input logic [7:0] w);
    return {w + 8'd3, w + 8'd2, w + 8'd1, w};
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Accepts rows first_row..3 of a tile whose first word is 'first', with
  // row_ready held high, then checks the tile_done pulse.
  task automatic drain(input logic [7:0] first, input int first_row, input bit start_in_done);
    int t;
    for (int r = first_row; r < 4; r++) begin
      t = 0;
      while (!row_valid && t < 50) begin
        @(negedge clk);
        t++;
      end
      chk("drain_row_valid", 64'(row_valid), 64'd1);
      chk("drain_row_data", 64'(row_data), 64'(row_of(first + 8'(4 * r))));
      @(negedge clk);
    end
    chk("drain_tile_done", 64'(tile_done), 64'd1);
    if (start_in_done) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("drain_tile_done_end", 64'(tile_done), 64'd0);
    chk("drain_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    int lat;
    int gap;
    logic [31:0] held;

    rstn        = 1'b0;
    start       = 1'b0;
    row_ready   = 1'b1;
    start2      = 1'b0;
    row_ready2  = 1'b1;
    fifo_empty2 = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_row_valid", 64'(row_valid), 64'd0);
    chk("rst_fifo_rd", 64'(fifo_rd), 64'd0);
    chk("rst_tile_done", 64'(tile_done), 64'd0);
    chk("rst_row_data", 64'(row_data), 64'd0);
    chk("rst_small_busy", 64'(busy2), 64'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Continuous FIFO, 0x01..0x10
    push(8'h01, 16);
    pulse_start();
    lat = 1;
    while (!row_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("cont_first_latency", 64'(lat), 64'd6);
    for (int r = 0; r < 4; r++) begin
      if (r > 0) begin
        gap = 0;
        while (!row_valid && gap < 50) begin
          @(negedge clk);
          gap++;
        end
        chk("cont_row_gap", 64'(gap), 64'd5);
      end
      chk("cont_row_data", 64'(row_data), 64'(row_of(8'(8'h01 + 4 * r))));
      @(negedge clk);
    end
    chk("cont_tile_done", 64'(tile_done), 64'd1);
    @(negedge clk);
    chk("cont_tile_done_once", 64'(tile_done), 64'd0);
    chk("cont_idle", 64'(busy), 64'd0);

    // Backpressure with ignored starts in FILL, PRESENT and DONE
    push(8'h21, 16);
    row_ready = 1'b0;
    pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!row_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_row_data", 64'(row_data), 64'h24232221);
    held = row_data;
    for (int i = 0; i < 8; i++) begin
      chk("bp_valid_held", 64'(row_valid), 64'd1);
      chk("bp_data_stable", 64'(row_data), 64'(held));
      chk("bp_no_pop", 64'(fifo_rd), 64'd0);
      start = (i == 3);
      @(negedge clk);
    end
    start = 1'b0;
    row_ready = 1'b1;
    @(negedge clk);
    chk("bp_accepted", 64'(row_valid), 64'd0);
    chk("bp_busy", 64'(busy), 64'd1);
    drain(8'h21, 1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("ign_start_idle", 64'(busy), 64'd0);
      chk("ign_no_extra_done", 64'(tile_done), 64'd0);
      @(negedge clk);
    end

    // Empty stall after two pops
    push(8'h41, 2);
    pulse_start();
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk("stall_no_pop", 64'(fifo_rd), 64'd0);
      chk("stall_no_valid", 64'(row_valid), 64'd0);
      @(negedge clk);
    end
    push(8'h43, 14);
    drain(8'h41, 0, 1'b0);

    // Reset mid-FILL with two words captured
    push(8'h61, 4);
    push(8'h71, 16);
    pulse_start();
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_row_valid", 64'(row_valid), 64'd0);
    chk("mid_rst_fifo_rd", 64'(fifo_rd), 64'd0);
    chk("mid_rst_row_data", 64'(row_data), 64'd0);
    @(negedge clk);
    chk("mid_rst_stays_idle", 64'(busy), 64'd0);
    pulse_start();
    drain(8'h71, 0, 1'b0);

    // ROWLEN=2, TILE_ROWS=1 instance
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    lat = 1;
    while (!row_valid2 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("small_latency", 64'(lat), 64'd4);
    chk("small_row_data", 64'(row_data2), 64'hA2A1);
    @(negedge clk);
    chk("small_tile_done", 64'(tile_done2), 64'd1);
    chk("small_valid_dropped", 64'(row_valid2), 64'd0);
    @(negedge clk);
    chk("small_tile_done_end", 64'(tile_done2), 64'd0);
    chk("small_idle", 64'(busy2), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
